lfsr_prbs_gen: RTL and testbench

LFSR_PRBS_GEN -- requirements
Module: lfsr_prbs_gen

---
 rtl/lfsr_prbs_gen_if.sv | 23 ++
 rtl/lfsr_prbs_gen.sv | 99 +++++++++
 tb/tb_lfsr_prbs_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_prbs_gen_if.sv
// rtl/lfsr_prbs_gen_if.sv - control/data bundle for the LFSR PRBS generator
interface lfsr_prbs_gen_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             seed_err;
  logic             wrap;
  logic [WIDTH-1:0] period_len;

  modport master (
    output en, load, seed_in,
    input  data_out, valid_out, seed_err, wrap, period_len
  );

  modport slave (
    input  en, load, seed_in,
    output data_out, valid_out, seed_err, wrap, period_len
  );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// rtl/lfsr_prbs_gen.sv - Fibonacci/Galois LFSR PRBS generator with seed load
// Optional period measurement (wrap, period_len) under macro LFSR_PERIOD_CNT_EN.
module lfsr_prbs_gen #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               MODE  = 0
) (
  input logic             clk,
  input logic             rst,
  lfsr_prbs_gen_if.slave  bus
);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_SEED = (SEED == '0) ? ONE : SEED;

  if (WIDTH < 3 || WIDTH > 32) begin : g_width_check
    $error("lfsr_prbs_gen: WIDTH must be in 3..32");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic             fb;
  logic             valid_q;
  logic             seed_err_q;

  always_comb begin
    fb         = ^(state & TAPS);
    next_state = state;
    if (MODE == 0) begin
      next_state = {state[WIDTH-2:0], fb};
    end else begin
      next_state = state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
    end
  end

  // Load beats en; an all-zero seed is replaced by 1 so the LFSR cannot lock up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_SEED;
      valid_q    <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      seed_err_q <= 1'b0;
      if (bus.load) begin
        if (bus.seed_in == '0) begin
          state      <= ONE;
          seed_err_q <= 1'b1;
        end else begin
          state <= bus.seed_in;
        end
      end else if (bus.en) begin
        state   <= next_state;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.data_out  = state;
  assign bus.valid_out = valid_q;
  assign bus.seed_err  = seed_err_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] start_seed;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] period_q;
  logic             wrap_q;

  // Period = steps taken to return to the most recent seed (reset or load).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_seed <= RST_SEED;
      step_cnt   <= '0;
      period_q   <= '0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.load) begin
        start_seed <= (bus.seed_in == '0) ? ONE : bus.seed_in;
        step_cnt   <= '0;
      end else if (bus.en) begin
        if (next_state == start_seed) begin
          wrap_q   <= 1'b1;
          period_q <= step_cnt + ONE;
          step_cnt <= '0;
        end else if (step_cnt != '1) begin
          step_cnt <= step_cnt + ONE;
        end
      end
    end
  end

  assign bus.wrap       = wrap_q;
  assign bus.period_len = period_q;
`else
  assign bus.wrap       = 1'b0;
  assign bus.period_len = '0;
`endif
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb/tb_lfsr_prbs_gen.sv - scoreboard bench: 4-bit Fibonacci, 4-bit Galois, 32-bit Galois
module tb_lfsr_prbs_gen;
`ifdef LFSR_PERIOD_CNT_EN
  localparam bit PCNT = 1'b1;
`else
  localparam bit PCNT = 1'b0;
`endif
  localparam int          W    [3] = '{4, 4, 32};
  localparam logic [31:0] TP   [3] = '{32'hC, 32'hC, 32'h80200003};
  localparam int          MD   [3] = '{0, 1, 1};
  localparam logic [3:0]  FIB8 [8] = '{4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5};
  localparam logic [3:0]  GAL8 [8] = '{4'd12, 4'd6, 4'd3, 4'd13, 4'd10, 4'd5, 4'd14, 4'd7};

  typedef struct packed {
    logic [2:0][31:0] data;
    logic [2:0]       v;
    logic [2:0]       se;
    logic [2:0]       wr;
    logic [2:0][31:0] pl;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] seed_in;

  logic [31:0] dout [3];
  logic [31:0] plen [3];
  logic [2:0]  vout, serr, wrp;

  exp_t        q[$];
  logic [31:0] st [3];
  logic [31:0] ss [3];
  logic [31:0] cnt [3];
  logic [31:0] pl [3];
  int          checks = 0;
  int          errors = 0;

  lfsr_prbs_gen_if #(.WIDTH(4))  if0 ();
  lfsr_prbs_gen_if #(.WIDTH(4))  if1 ();
  lfsr_prbs_gen_if #(.WIDTH(32)) if2 ();

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  lfsr_prbs_gen #(.MODE(1))                                          dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.en = en;  assign if0.load = load;  assign if0.seed_in = seed_in[3:0];
  assign if1.en = en;  assign if1.load = load;  assign if1.seed_in = seed_in[3:0];
  assign if2.en = en;  assign if2.load = load;  assign if2.seed_in = seed_in;

  assign dout[0] = 32'(if0.data_out);   assign plen[0] = 32'(if0.period_len);
  assign dout[1] = 32'(if1.data_out);   assign plen[1] = 32'(if1.period_len);
  assign dout[2] = if2.data_out;        assign plen[2] = if2.period_len;
  assign vout = {if2.valid_out, if1.valid_out, if0.valid_out};
  assign serr = {if2.seed_err, if1.seed_err, if0.seed_err};
  assign wrp  = {if2.wrap, if1.wrap, if0.wrap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  function automatic logic [31:0] msk(input int d);
    return (W[d] == 32) ? 32'hFFFF_FFFF : ((32'h1 << W[d]) - 32'h1);
  endfunction

  // Reference step taken straight from the polynomial definitions.
  function automatic logic [31:0] step(input int d, input logic [31:0] s);
    if (MD[d] == 1) return s[0] ? ((s >> 1) ^ TP[d]) : (s >> 1);
    return ((s << 1) | 32'($countones(s & TP[d]) % 2)) & msk(d);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      st[d] = 1; ss[d] = 1; cnt[d] = 0; pl[d] = 0;
    end
  endtask

  // Applies the inputs seen at this edge to the model and queues the expected outputs.
  task automatic model_edge();
    exp_t e;
    logic [31:0] s, n;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      s = seed_in & msk(d);
      if (rst) begin
        st[d] = 1; ss[d] = 1; cnt[d] = 0; pl[d] = 0;
      end else if (load) begin
        if (s == 0) begin
          st[d] = 1; e.se[d] = 1'b1;
        end else begin
          st[d] = s;
        end
        ss[d] = st[d]; cnt[d] = 0;
      end else if (en) begin
        n = step(d, st[d]);
        e.v[d] = 1'b1;
        if (PCNT) begin
          if (n == ss[d]) begin
            e.wr[d] = 1'b1; pl[d] = (cnt[d] + 1) & msk(d); cnt[d] = 0;
          end else if (cnt[d] != msk(d)) begin
            cnt[d] = cnt[d] + 1;
          end
        end
        st[d] = n;
      end
      e.data[d] = st[d];
      e.pl[d]   = pl[d];
    end
    q.push_back(e);
  endtask

  task automatic cyc(input bit e, input bit l, input logic [31:0] s);
    en = e; load = l; seed_in = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Entered at posedge+1: asserts rst mid-cycle, checks it acts immediately, releases after an edge.
  task automatic async_reset();
    en = 1'b1; load = $urandom_range(0, 1) == 1; seed_in = $urandom;
    #5;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("async_rst_data", d, dout[d], 32'd1);
      chk("async_rst_plen", d, plen[d], 32'd0);
    end
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        chk("data_out", d, dout[d], e.data[d]);
        chk("valid_out", d, 32'(vout[d]), 32'(e.v[d]));
        chk("seed_err", d, 32'(serr[d]), 32'(e.se[d]));
        chk("wrap", d, 32'(wrp[d]), 32'(e.wr[d]));
        chk("period_len", d, plen[d], e.pl[d]);
      end
    end
  end

  initial begin
    int nval, nzero;
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_data", d, dout[d], 32'd1);
      chk("reset_valid", d, 32'(vout[d]), 32'd0);
      chk("reset_plen", d, plen[d], 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (i < 8) begin
        chk("fib_seq", 0, dout[0], 32'(FIB8[i]));
        chk("gal_seq", 1, dout[1], 32'(GAL8[i]));
      end
    end
    chk("wrap_15th", 1, 32'(wrp[1]), 32'(PCNT));
    chk("plen_15", 1, plen[1], PCNT ? 32'd15 : 32'd0);

    cyc(1'b1, 1'b1, 32'h0);
    chk("zero_seed_data", 0, dout[0], 32'd1);
    chk("zero_seed_err", 0, 32'(serr[0]), 32'd1);
    chk("zero_seed_valid", 0, 32'(vout[0]), 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("seed_err_pulse", 0, 32'(serr[0]), 32'd0);
    cyc(1'b1, 1'b1, 32'h5);
    chk("load_prio_data", 0, dout[0], 32'd5);
    chk("load_prio_valid", 0, 32'(vout[0]), 32'd0);

    repeat (7) cyc(1'b1, 1'b0, '0);
    async_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("restart_seq", 0, dout[0], 32'(FIB8[i]));
    end

    async_reset();
    nval = 0; nzero = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b0, '0);
      nval  += int'(vout[2]);
      nzero += int'(dout[2] == 0);
    end
    chk("valid_pulses_100", 2, 32'(nval), 32'd100);
    chk("no_zero_state", 2, 32'(nzero), 32'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
